// File: rtl/alu_ctrl.sv
// Sequencing front end for the 8-bit ALU: byte-stream decode, immediate fetch, accumulator/register file and flags.
// Optional build macro: ALU_CTRL_CARRY_EN enables the carry/borrow flag datapath.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_y,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       zero,
  output logic       carry,
  output logic       err
);

  localparam int unsigned DW   = 8;
  localparam int unsigned OW   = 4;
  localparam int unsigned RW   = 2;
  localparam int unsigned NREG = 4;

  localparam logic [OW-1:0] OP_ADD   = 4'h4;
  localparam logic [OW-1:0] OP_SUB   = 4'h5;
  localparam logic [OW-1:0] OP_STORE = 4'h8;

  typedef enum logic [1:0] {FETCH, IMM, EXEC, DONE} state_t;

  state_t        state;
  logic [OW-1:0] op_q;
  logic [RW-1:0] rsel_q;
  logic [DW-1:0] acc;
  logic [DW-1:0] rf [NREG];

  logic          fire_c;
  logic [OW-1:0] in_op_c;
  logic          in_imm_c;
  logic [RW-1:0] in_rsel_c;
  logic          unused_instr_c;

  assign fire_c         = instr_valid && instr_ready;
  assign in_op_c        = instr[7:4];
  assign in_imm_c       = instr[3];
  assign in_rsel_c      = instr[1:0];
  assign unused_instr_c = instr[2];

`ifdef ALU_CTRL_CARRY_EN
  // 9-bit add for carry-out; borrow is a plain unsigned compare of acc and B.
  logic [DW:0] sum9_c;
  logic        carry_nxt_c;
  logic        unused_sum_c;

  assign sum9_c       = {1'b0, acc} + {1'b0, alu_b};
  assign unused_sum_c = ^sum9_c[DW-1:0];

  always_comb begin
    carry_nxt_c = 1'b0;
    if (op_q == OP_ADD)      carry_nxt_c = sum9_c[DW];
    else if (op_q == OP_SUB) carry_nxt_c = (acc < alu_b);
  end
`else
  assign carry = 1'b0;
`endif

  // Control FSM; every output except carry (tied off when disabled) is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      op_q        <= '0;
      rsel_q      <= '0;
      acc         <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      instr_ready <= 1'b1;
      alu_opcode  <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      zero        <= 1'b0;
      err         <= 1'b0;
`ifdef ALU_CTRL_CARRY_EN
      carry       <= 1'b0;
`endif
    end else begin
      res_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        FETCH: begin
          if (fire_c) begin
            op_q   <= in_op_c;
            rsel_q <= in_rsel_c;
            if (!in_op_c[3] && in_imm_c) begin
              state <= IMM;
            end else begin
              state       <= EXEC;
              instr_ready <= 1'b0;
              // STORE and illegal ops never reach the ALU pins
              if (!in_op_c[3]) begin
                alu_opcode <= in_op_c;
                alu_a      <= acc;
                alu_b      <= rf[in_rsel_c];
              end
            end
          end
        end
        IMM: begin
          if (fire_c) begin
            state       <= EXEC;
            instr_ready <= 1'b0;
            alu_opcode  <= op_q;
            alu_a       <= acc;
            alu_b       <= instr;
          end
        end
        EXEC: begin
          state <= DONE;
          if (!op_q[3]) begin
            acc       <= alu_y;
            res_data  <= alu_y;
            zero      <= (alu_y == '0);
            res_valid <= 1'b1;
`ifdef ALU_CTRL_CARRY_EN
            carry     <= carry_nxt_c;
`endif
          end else if (op_q == OP_STORE) begin
            rf[rsel_q] <= acc;
            res_data   <= acc;
            res_valid  <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
        DONE: begin
          state       <= FETCH;
          instr_ready <= 1'b1;
        end
        default: begin
          state       <= FETCH;
          instr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
